// File: rtl/chimera_pkg.sv
// Shared chimera definitions: wide AXI request/response types, the bypass
// controller FSM state type and the default outstanding-transaction limit.
package chimera_pkg;

  localparam int unsigned ChimeraMaxTxns = 16;

  localparam int unsigned WideAddrW = 48;
  localparam int unsigned WideDataW = 512;
  localparam int unsigned WideIdW   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2
  } byp_state_e;

  typedef struct packed {
    logic [WideIdW-1:0]     aw_id;
    logic [WideAddrW-1:0]   aw_addr;
    logic [7:0]             aw_len;
    logic                   aw_valid;
    logic [WideDataW-1:0]   w_data;
    logic [WideDataW/8-1:0] w_strb;
    logic                   w_last;
    logic                   w_valid;
    logic                   b_ready;
    logic [WideIdW-1:0]     ar_id;
    logic [WideAddrW-1:0]   ar_addr;
    logic [7:0]             ar_len;
    logic                   ar_valid;
    logic                   r_ready;
  } wide_req_t;

  typedef struct packed {
    logic                 aw_ready;
    logic                 ar_ready;
    logic                 w_ready;
    logic [WideIdW-1:0]   b_id;
    logic [1:0]           b_resp;
    logic                 b_valid;
    logic [WideIdW-1:0]   r_id;
    logic [WideDataW-1:0] r_data;
    logic [1:0]           r_resp;
    logic                 r_last;
    logic                 r_valid;
  } wide_resp_t;

endpackage

// File: rtl/chimera_txn_counter.sv
// Saturating up/down counter of outstanding transactions. A simultaneous
// increment and decrement cancel out; the count never wraps in either direction.
module chimera_txn_counter
  import chimera_pkg::*;
#(
  parameter int unsigned MaxTxns = ChimeraMaxTxns
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             inc,
  input  logic                             dec,
  output logic [$clog2(MaxTxns+1)-1:0]     count_next,
  output logic                             full
);

  localparam int unsigned CntW = $clog2(MaxTxns + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxTxns);

  logic [CntW-1:0] count_q, count_d;

  // Next count: step by one unless both events coincide or a bound is reached
  always_comb begin
    count_d = count_q;
    if (inc && !dec && (count_q != MaxCnt)) begin
      count_d = count_q + 1'b1;
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register, cleared by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_next = count_d;
  assign full       = (count_q == MaxCnt);

  // A completion with nothing outstanding means the downstream broke protocol
  dec_at_zero_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(dec && !inc && (count_q == '0)));

endmodule

// File: rtl/chimera_wide_bypass_ctrl.sv
// Wide-path bypass controller. Sits between the wide CDC and the wide demux and
// changes the demux bypass select only once every outstanding write and read
// has completed, blocking new AW/AR admission while a change is pending.
module chimera_wide_bypass_ctrl
  import chimera_pkg::*;
#(
  parameter int unsigned MaxTxns      = ChimeraMaxTxns,
  parameter logic        BypassRstVal = 1'b0,
  parameter type         axi_req_t    = wide_req_t,
  parameter type         axi_resp_t   = wide_resp_t
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  axi_req_t  slv_req_i,
  output axi_resp_t slv_resp_o,
  output axi_req_t  mst_req_o,
  input  axi_resp_t mst_resp_i,
  input  logic      bypass_req_i,
  output logic      bypass_mode_o,
  output logic      busy_o,
  output logic      switch_done_o
);

  localparam int unsigned CntW = $clog2(MaxTxns + 1);

  byp_state_e      state_q, state_d;
  logic [CntW-1:0] wr_cnt_next, rd_cnt_next;
  logic            wr_full, rd_full;
  logic            aw_hold_q, aw_hold_d, ar_hold_q, ar_hold_d;
  logic            aw_open, ar_open;
  logic            mst_aw_valid, mst_ar_valid;
  logic            aw_hs, ar_hs, b_hs, r_last_hs;
  logic            drained, toggle;
  logic            mode_q, done_q;

  // A held address must stay valid; otherwise admit only when idle and not saturated
  assign aw_open = aw_hold_q | ((state_q == IDLE) & ~wr_full);
  assign ar_open = ar_hold_q | ((state_q == IDLE) & ~rd_full);

  assign mst_aw_valid = slv_req_i.aw_valid & aw_open;
  assign mst_ar_valid = slv_req_i.ar_valid & ar_open;

  // Everything passes straight through except the gated AW/AR handshake pairs
  always_comb begin
    mst_req_o           = slv_req_i;
    mst_req_o.aw_valid  = mst_aw_valid;
    mst_req_o.ar_valid  = mst_ar_valid;
    slv_resp_o          = mst_resp_i;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_open;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_open;
  end

  assign aw_hs     = mst_aw_valid & mst_resp_i.aw_ready;
  assign ar_hs     = mst_ar_valid & mst_resp_i.ar_ready;
  assign b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;
  assign r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r_last;

  assign aw_hold_d = mst_aw_valid & ~mst_resp_i.aw_ready;
  assign ar_hold_d = mst_ar_valid & ~mst_resp_i.ar_ready;

  // Remember an address that went valid downstream but has not been accepted yet
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_hold_q <= 1'b0;
      ar_hold_q <= 1'b0;
    end else begin
      aw_hold_q <= aw_hold_d;
      ar_hold_q <= ar_hold_d;
    end
  end

  chimera_txn_counter #(
    .MaxTxns (MaxTxns)
  ) i_wr_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .inc        (aw_hs),
    .dec        (b_hs),
    .count_next (wr_cnt_next),
    .full       (wr_full)
  );

  chimera_txn_counter #(
    .MaxTxns (MaxTxns)
  ) i_rd_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .inc        (ar_hs),
    .dec        (r_last_hs),
    .count_next (rd_cnt_next),
    .full       (rd_full)
  );

  // Drained as of the coming edge: both counts reach zero and nothing is held
  assign drained = (wr_cnt_next == '0) && (rd_cnt_next == '0) && !aw_hold_d && !ar_hold_d;

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a started drain always runs to a switch, even if the request flips back
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bypass_req_i != mode_q) state_d = DRAIN;
      DRAIN:   if (drained) state_d = SWITCH;
      SWITCH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_o = (state_q != IDLE);
    toggle = (state_q == SWITCH);
  end

  // Applied mode flips on leaving SWITCH; the done pulse coincides with the new mode
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q <= BypassRstVal;
      done_q <= 1'b0;
    end else begin
      if (toggle) begin
        mode_q <= ~mode_q;
      end
      done_q <= toggle;
    end
  end

  assign bypass_mode_o = mode_q;
  assign switch_done_o = done_q;

endmodule

// File: tb/tb_chimera_wide_bypass_ctrl.sv
// Bench for the wide bypass controller. Directed vectors push expected switch
// events and expected downstream AW/AR addresses into queues; a negedge monitor
// pops and compares whenever the DUT pulses switch_done or hands off an address.
module tb_chimera_wide_bypass_ctrl;
  import chimera_pkg::*;

  localparam int unsigned MaxTxns = 4;

  typedef struct {
    int   cyc;
    logic mode;
  } sw_exp_t;

  logic       clk;
  logic       rst_n;
  wide_req_t  slv_req, mst_req;
  wide_resp_t slv_resp, mst_resp;
  logic       bypass_req, bypass_mode, busy, switch_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int c;

  sw_exp_t              sw_q[$];
  logic [WideAddrW-1:0] aw_q[$];
  logic [WideAddrW-1:0] ar_q[$];
  sw_exp_t              mon_e;
  logic [WideAddrW-1:0] mon_a;
  logic [WideAddrW-1:0] addr;

  chimera_wide_bypass_ctrl #(
    .MaxTxns      (MaxTxns),
    .BypassRstVal (1'b0),
    .axi_req_t    (wide_req_t),
    .axi_resp_t   (wide_resp_t)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .slv_req_i     (slv_req),
    .slv_resp_o    (slv_resp),
    .mst_req_o     (mst_req),
    .mst_resp_i    (mst_resp),
    .bypass_req_i  (bypass_req),
    .bypass_mode_o (bypass_mode),
    .busy_o        (busy),
    .switch_done_o (switch_done)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle stamp used to time expected switch events
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic aw_v, input logic [WideAddrW-1:0] aw_a, input logic aw_r,
                               input logic ar_v, input logic [WideAddrW-1:0] ar_a, input logic ar_r,
                               input logic b_v, input logic r_v, input logic r_l, input logic req);
    slv_req.aw_valid  = aw_v;
    slv_req.aw_addr   = aw_a;
    mst_resp.aw_ready = aw_r;
    slv_req.ar_valid  = ar_v;
    slv_req.ar_addr   = ar_a;
    mst_resp.ar_ready = ar_r;
    mst_resp.b_valid  = b_v;
    mst_resp.r_valid  = r_v;
    mst_resp.r_last   = r_l;
    bypass_req        = req;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compare every switch pulse and every downstream AW/AR handoff
  always @(negedge clk) begin
    if (rst_n) begin
      if (switch_done === 1'b1) begin
        if (sw_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_switch: got pulse at cycle %0d expected none", cyc);
        end else begin
          mon_e = sw_q.pop_front();
          checkOutput("switch_cycle", 64'(cyc), 64'(mon_e.cyc));
          checkOutput("switch_mode", 64'(bypass_mode), 64'(mon_e.mode));
        end
      end
      if (mst_req.aw_valid && mst_resp.aw_ready) begin
        if (aw_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_aw: got addr %0h expected none", mst_req.aw_addr);
        end else begin
          mon_a = aw_q.pop_front();
          checkOutput("aw_addr", 64'(mst_req.aw_addr), 64'(mon_a));
        end
      end
      if (mst_req.ar_valid && mst_resp.ar_ready) begin
        if (ar_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_ar: got addr %0h expected none", mst_req.ar_addr);
        end else begin
          mon_a = ar_q.pop_front();
          checkOutput("ar_addr", 64'(mst_req.ar_addr), 64'(mon_a));
        end
      end
    end
  end

  initial begin
    slv_req         = '0;
    mst_resp        = '0;
    slv_req.b_ready = 1'b1;
    slv_req.r_ready = 1'b1;
    bypass_req      = 1'b0;
    rst_n           = 1'b0;
    tick(3);

    $display("[TB] reset state");
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_mode", 64'(bypass_mode), 64'(0));
    checkOutput("rst_done", 64'(switch_done), 64'(0));
    rst_n = 1'b1;
    tick(2);

    $display("[TB] pass-through");
    slv_req.w_data[31:0]  = 32'hCAFEF00D;
    slv_req.w_valid       = 1'b1;
    mst_resp.r_data[31:0] = 32'h12345678;
    mst_resp.w_ready      = 1'b1;
    #1;
    checkOutput("pt_w_data", 64'(mst_req.w_data[31:0]), 64'h00000000CAFEF00D);
    checkOutput("pt_w_valid", 64'(mst_req.w_valid), 64'(1));
    checkOutput("pt_r_data", 64'(slv_resp.r_data[31:0]), 64'h0000000012345678);
    checkOutput("pt_w_ready", 64'(slv_resp.w_ready), 64'(1));
    slv_req.w_valid  = 1'b0;
    mst_resp.w_ready = 1'b0;
    tick(1);

    $display("[TB] idle toggle");
    c = cyc;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    sw_q.push_back('{c + 3, 1'b1});
    tick(1);
    checkOutput("idle_busy", 64'(busy), 64'(1));
    tick(2);
    checkOutput("idle_mode", 64'(bypass_mode), 64'(1));
    checkOutput("idle_busy_clear", 64'(busy), 64'(0));
    tick(2);

    $display("[TB] drain with three writes");
    for (int i = 0; i < 3; i++) begin
      addr = 48'h1000 + 48'(i) * 48'h40;
      applyStimulus(1'b1, addr, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      aw_q.push_back(addr);
      tick(1);
    end
    c = cyc;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b1, 48'h2000, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    aw_q.push_back(48'h2000);
    sw_q.push_back('{c + 5, 1'b0});
    #1;
    checkOutput("drain_aw_blocked", 64'(mst_req.aw_valid), 64'(0));
    checkOutput("drain_aw_ready_blocked", 64'(slv_resp.aw_ready), 64'(0));
    checkOutput("drain_busy", 64'(busy), 64'(1));
    tick(3);
    applyStimulus(1'b1, 48'h2000, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("switch_aw_blocked", 64'(mst_req.aw_valid), 64'(0));
    tick(1);
    checkOutput("drain_mode", 64'(bypass_mode), 64'(0));
    checkOutput("post_switch_aw_open", 64'(mst_req.aw_valid), 64'(1));
    tick(1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(2);

    $display("[TB] held AW across toggle");
    c = cyc;
    applyStimulus(1'b1, 48'h3000, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b1, 48'h3000, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1);
    checkOutput("held_aw_valid", 64'(mst_req.aw_valid), 64'(1));
    checkOutput("held_busy", 64'(busy), 64'(1));
    tick(1);
    checkOutput("held_aw_valid_2", 64'(mst_req.aw_valid), 64'(1));
    applyStimulus(1'b1, 48'h3000, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    aw_q.push_back(48'h3000);
    tick(1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(2);
    checkOutput("held_wait_b", 64'(busy), 64'(1));
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    sw_q.push_back('{c + 8, 1'b1});
    tick(1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1);
    checkOutput("held_mode", 64'(bypass_mode), 64'(1));
    tick(2);

    $display("[TB] read saturation");
    for (int i = 0; i < 4; i++) begin
      addr = 48'h100 + 48'(i);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, addr, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      ar_q.push_back(addr);
      tick(1);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 48'h104, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("sat_ar_blocked", 64'(mst_req.ar_valid), 64'(0));
    checkOutput("sat_ar_ready_blocked", 64'(slv_resp.ar_ready), 64'(0));
    tick(1);
    applyStimulus(1'b1, 48'h5000, 1'b1, 1'b1, 48'h104, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    aw_q.push_back(48'h5000);
    #1;
    checkOutput("sat_aw_free", 64'(mst_req.aw_valid), 64'(1));
    tick(1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 48'h104, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    tick(1);
    checkOutput("sat_nonlast_blocked", 64'(mst_req.ar_valid), 64'(0));
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 48'h104, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    tick(1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 48'h104, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    ar_q.push_back(48'h104);
    #1;
    checkOutput("sat_released", 64'(mst_req.ar_valid), 64'(1));
    tick(1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(1);

    $display("[TB] simultaneous AR and last R");
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick(2);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 48'h200, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    ar_q.push_back(48'h200);
    tick(1);
    for (int i = 1; i < 3; i++) begin
      addr = 48'h200 + 48'(i);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, addr, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      ar_q.push_back(addr);
      tick(1);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 48'h203, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("simul_full", 64'(mst_req.ar_valid), 64'(0));
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick(4);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1);

    $display("[TB] toggle with all counts drained");
    c = cyc;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sw_q.push_back('{c + 3, 1'b0});
    tick(1);
    checkOutput("clean_busy", 64'(busy), 64'(1));
    tick(3);

    $display("[TB] reset during drain");
    for (int i = 0; i < 2; i++) begin
      addr = 48'h600 + 48'(i);
      applyStimulus(1'b1, addr, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      aw_q.push_back(addr);
      tick(1);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(2);
    checkOutput("rdrain_busy", 64'(busy), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rdrain_busy_rst", 64'(busy), 64'(0));
    checkOutput("rdrain_mode_rst", 64'(bypass_mode), 64'(0));
    checkOutput("rdrain_done_rst", 64'(switch_done), 64'(0));
    tick(1);
    rst_n = 1'b1;
    c = cyc;
    sw_q.push_back('{c + 3, 1'b1});
    tick(1);
    checkOutput("rdrain_restart_busy", 64'(busy), 64'(1));
    tick(3);
    checkOutput("rdrain_restart_mode", 64'(bypass_mode), 64'(1));
    tick(3);

    checkOutput("sw_queue_empty", 64'(sw_q.size()), 64'(0));
    checkOutput("aw_queue_empty", 64'(aw_q.size()), 64'(0));
    checkOutput("ar_queue_empty", 64'(ar_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
